serial_add_ctrl: RTL and testbench

Bit-serial addition controller. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It feeds them LSB-first through a single 1-bit full-adder cell, one bit per clock, holding the carry in a flop between bits. It then presents the assembled sum, carry-out and signed overflow through an output valid/ready handshake. It is the area-minimal adder path for low-rate arithmetic blocks in the adder library.

---
 rtl/adder_pkg.sv | 18 +
 rtl/fulladder.sv | 13 +
 rtl/serial_add_ctrl.sv | 109 ++++++++++
 tb/tb_serial_add_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder library: FSM state encoding,
// bit-counter width derivation and the default operand width.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full-adder cell; the only arithmetic in the serial adder path.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carryout
);

  assign sum      = a ^ b ^ c;
  assign carryout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: operands are shifted LSB-first through one full-adder cell,
// with the carry held in a single flop between bits.
module serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r;
  logic [WIDTH:0]   sum_cat;
  logic [CNT_W-1:0] cnt;
  logic             carry, cout_r, ovf_r;
  logic             cell_s, cell_c;
  logic             accept, last;

  fulladder u_cell (
    .a        (a_sh[0]),
    .b        (b_sh[0]),
    .c        (carry),
    .sum      (cell_s),
    .carryout (cell_c)
  );

  assign accept  = in_valid & in_ready;
  assign last    = (cnt == LAST);
  assign sum_cat = {cell_s, sum_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // In DONE, the output handshake frees the block in the same cycle, so a
  // new operand set can be taken straight into RUN.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      sum_r <= sum_cat[WIDTH:1];
      carry <= cell_c;
      if (last) begin
        // carry here is still the carry into the MSB
        cout_r <= cell_c;
        ovf_r  <= carry ^ cell_c;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic       in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
  logic [7:0] a, b, sum;

  logic       iv1, ir1, cin1, ov1, or1, co1, ovf1, busy1;
  logic [0:0] a1, b1, s1;

  int cmp = 0;
  int mis = 0;
  bit rnd_done = 1'b0;

  logic [9:0] q8[$];
  logic [2:0] q1[$];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(ov1), .out_ready(or1),
    .sum(s1), .cout(co1), .ovf(ovf1), .busy(busy1)
  );

  // Reference: plain integer addition; overflow when like-signed operands
  // produce a differently-signed result.
  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic ci);
    int unsigned t;
    logic [7:0]  s;
    logic        v;
    t = 32'(x) + 32'(y) + 32'(ci);
    s = t[7:0];
    v = (x[7] == y[7]) && (s[7] != x[7]);
    return {s, t[8], v};
  endfunction

  function automatic logic [2:0] model1(input logic x, input logic y, input logic ci);
    int unsigned t;
    t = 32'(x) + 32'(y) + 32'(ci);
    return {t[0], t[1], (x == y) && (t[0] != x)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    cmp++;
    mis++;
    $display("FAIL %s", nm);
  endtask

  initial begin : mon8
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (q8.size() == 0) fail_now("unexpected_result8");
        else begin
          e = q8.pop_front();
          chk("sum8",  32'(sum),  32'(e[9:2]));
          chk("cout8", 32'(cout), 32'(e[1]));
          chk("ovf8",  32'(ovf),  32'(e[0]));
        end
      end
    end
  end

  initial begin : mon1
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && ov1 && or1) begin
        if (q1.size() == 0) fail_now("unexpected_result1");
        else begin
          e = q1.pop_front();
          chk("sum1",  32'(s1),   32'(e[2]));
          chk("cout1", 32'(co1),  32'(e[1]));
          chk("ovf1",  32'(ovf1), 32'(e[0]));
        end
      end
    end
  end

  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic ci);
    int n = 0;
    @(posedge clk); #1;
    a = x; b = y; cin = ci; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 200) break;
    end
    if (n > 200) begin
      fail_now("accept_timeout8");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      q8.push_back(model8(x, y, ci));
      #1 in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    end
  endtask

  task automatic send1(input logic x, input logic y, input logic ci);
    int n = 0;
    @(posedge clk); #1;
    a1 = x; b1 = y; cin1 = ci; iv1 = 1'b1;
    forever begin
      @(negedge clk);
      if (ir1) break;
      if (++n > 200) break;
    end
    if (n > 200) begin
      fail_now("accept_timeout1");
      iv1 = 1'b0;
    end else begin
      @(posedge clk);
      q1.push_back(model1(x, y, ci));
      #1 iv1 = 1'b0;
      a1 = 1'($urandom); b1 = 1'($urandom);
    end
  endtask

  task automatic drain;
    int n = 0;
    while ((q8.size() != 0 || q1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now("drain_timeout");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    iv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; or1 = 1'b1;
    #3;
    chk("reset_flags8", 32'({in_ready, out_valid, busy}), 32'(3'b100));
    chk("reset_data8",  32'({sum, cout, ovf}), 32'(0));
    chk("reset_flags1", 32'({ir1, ov1, busy1, s1, co1, ovf1}), 32'(6'b100000));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Latency and RUN flags: 0x5A + 0x3C
    send8(8'h5A, 8'h3C, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("run_flags", 32'({busy, in_ready, out_valid}), 32'(3'b100));
    end
    @(negedge clk);
    chk("latency_out_valid", 32'(out_valid), 32'(1));
    chk("directed_5a3c", 32'({sum, cout, ovf}), 32'({8'h96, 1'b0, 1'b1}));
    drain();

    send8(8'hFF, 8'h01, 1'b0);
    send8(8'h80, 8'h80, 1'b0);
    send8(8'h00, 8'h00, 1'b1);
    drain();

    // Backpressure then back-to-back accept on the output handshake
    @(posedge clk); #1 out_ready = 1'b0;
    send8(8'h12, 8'h34, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("done_timeout");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_flags", 32'({out_valid, in_ready, busy}), 32'(3'b100));
      chk("hold_data",  32'({sum, cout, ovf}), 32'({8'h46, 1'b0, 1'b0}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    @(negedge clk);
    chk("b2b_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    q8.push_back(model8(8'h01, 8'h02, 1'b0));
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_no_bubble", 32'({busy, out_valid}), 32'(2'b10));
    drain();

    // Asynchronous reset in the middle of RUN
    send8(8'h77, 8'h11, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_flags", 32'({in_ready, out_valid, busy}), 32'(3'b100));
    chk("async_rst_data",  32'({sum, cout, ovf}), 32'(0));
    q8.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("no_pulse_after_rst", 32'(pulses), 32'(0));
    send8(8'h10, 8'h20, 1'b0);
    drain();

    // WIDTH=1: result after 2 edges
    send1(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("w1_run", 32'({busy1, ov1}), 32'(2'b10));
    @(negedge clk);
    chk("w1_result", 32'({ov1, s1, co1, ovf1}), 32'(4'b1110));
    drain();
    for (int i = 0; i < 8; i++) send1(1'(i >> 2), 1'(i >> 1), 1'(i));
    drain();

    // Randomised traffic with random backpressure
    fork
      begin
        fork
          for (int i = 0; i < 60; i++) begin
            send8(8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
          end
          for (int j = 0; j < 30; j++) begin
            send1(1'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
          end
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          or1       = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1; or1 = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
